// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter: round-robin scheduler that shares one MSB-first
// parallel_to_serial shifter between NREQ requesters. It grants a requester,
// latches its word, sequences the shifter load/enable, acknowledges on done,
// and enforces an inter-frame gap. A shifter watchdog raises err on timeout.
module serial_tx_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int GAP   = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] data_in,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       ack,
    output logic                  err,
    output logic                  busy,
    output logic                  sh_load,
    output logic                  sh_enable,
    output logic [WIDTH-1:0]      sh_data,
    input  logic                  sh_done
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WD_W  = $clog2(WIDTH + 5);
    localparam int GAP_W = 5;

    // Last SHIFT cycle index before the watchdog gives up (WIDTH+4 cycles total)
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(WIDTH + 3);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_ACK,
        S_GAP
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [IDX_W-1:0]   r_last_grant;
    logic [IDX_W-1:0]   w_winner;
    logic               w_any;
    logic               w_arb_win;
    logic               w_timeout;
    logic [WD_W-1:0]    r_wdog;
    logic [GAP_W-1:0]   r_gap_cnt;

    // Round-robin pick: search starts one past the last winner and wraps.
    function automatic logic [IDX_W-1:0] f_rr_pick(
        input logic [NREQ-1:0]  req_v,
        input logic [IDX_W-1:0] last
    );
        int   idx;
        logic found;
        f_rr_pick = last;
        found     = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = int'(last) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req_v[idx[IDX_W-1:0]]) begin
                found     = 1'b1;
                f_rr_pick = idx[IDX_W-1:0];
            end
        end
    endfunction

    assign w_any     = |req;
    assign w_winner  = f_rr_pick(req, r_last_grant);
    assign w_timeout = (r_state == S_SHIFT) && !sh_done && (r_wdog == WD_LAST);

    // Control outputs decoded straight from the registered state
    assign busy      = (r_state != S_IDLE);
    assign sh_load   = (r_state == S_LOAD);
    assign sh_enable = (r_state == S_SHIFT);

    // Next-state logic; the edge that closes the gap (or ACK when GAP=0)
    // arbitrates directly so the frame period is WIDTH+3+GAP cycles.
    always_comb begin
        w_next_state = r_state;
        w_arb_win    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_next_state = S_LOAD;
                    w_arb_win    = 1'b1;
                end
            end
            S_LOAD: begin
                w_next_state = S_SHIFT;
            end
            S_SHIFT: begin
                if (sh_done) begin
                    w_next_state = S_ACK;
                end else if (r_wdog == WD_LAST) begin
                    w_next_state = (GAP == 0) ? S_IDLE : S_GAP;
                end
            end
            S_ACK: begin
                if (GAP != 0) begin
                    w_next_state = S_GAP;
                end else if (w_any) begin
                    w_next_state = S_LOAD;
                    w_arb_win    = 1'b1;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    if (w_any) begin
                        w_next_state = S_LOAD;
                        w_arb_win    = 1'b1;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Grant, ack and err pulses plus round-robin pointer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant        <= '0;
            ack          <= '0;
            err          <= 1'b0;
            r_last_grant <= IDX_W'(NREQ - 1);
        end else begin
            ack <= '0;
            err <= w_timeout;
            if (w_arb_win) begin
                grant        <= {{(NREQ-1){1'b0}}, 1'b1} << w_winner;
                r_last_grant <= w_winner;
            end else if (w_timeout || (r_state == S_ACK)) begin
                grant <= '0;
            end
            if ((r_state == S_SHIFT) && sh_done) begin
                ack <= grant;
            end
        end
    end

    // Word latch: captured only on the grant edge, later data_in is ignored
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_data <= '0;
        end else if (w_arb_win) begin
            sh_data <= data_in[int'(w_winner)*WIDTH +: WIDTH];
        end
    end

    // Watchdog and gap counters, cleared whenever their state is left
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wdog    <= '0;
            r_gap_cnt <= '0;
        end else begin
            r_wdog    <= (r_state == S_SHIFT) ? r_wdog + 1'b1 : '0;
            r_gap_cnt <= (r_state == S_GAP) ? r_gap_cnt + 1'b1 : '0;
        end
    end

endmodule
